// File: rtl/td4_pkg.sv
// td4_pkg: shared definitions for the 4-bit CPU front end.
//   - OP_*       : 4-bit opcodes (instruction bits [7:4])
//   - SEL_*      : datapath source select encodings, {select_b, select_a}
//   - state_e    : run/step control FSM states
package td4_pkg;

  localparam logic [3:0] OP_ADD_A    = 4'b0000;
  localparam logic [3:0] OP_MOV_AB   = 4'b0001;
  localparam logic [3:0] OP_IN_A     = 4'b0010;
  localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
  localparam logic [3:0] OP_MOV_BA   = 4'b0100;
  localparam logic [3:0] OP_ADD_B    = 4'b0101;
  localparam logic [3:0] OP_IN_B     = 4'b0110;
  localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
  localparam logic [3:0] OP_OUT_B    = 4'b1001;
  localparam logic [3:0] OP_OUT_IM   = 4'b1011;
  localparam logic [3:0] OP_JNC      = 4'b1110;
  localparam logic [3:0] OP_JMP      = 4'b1111;

  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_IN   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_e;

endpackage

// File: rtl/td4_decoder.sv
// td4_decoder: combinational instruction decoder.
//   op     in  4  opcode, instruction bits [7:4]
//   carry  in  1  registered carry flag (used by JNC)
//   sel    out 2  source select {select_b, select_a}
//   load   out 4  write enables {PC, out reg, B, A}, not gated by run state
//   add_op out 1  instruction is an ADD, so the carry flag captures c_in
module td4_decoder
  import td4_pkg::*;
(
  input  logic [3:0] op,
  input  logic       carry,
  output logic [1:0] sel,
  output logic [3:0] load,
  output logic       add_op
);

  always_comb begin
    sel    = SEL_ZERO;
    load   = 4'b0000;
    add_op = 1'b0;
    case (op)
      OP_ADD_A:    begin sel = SEL_A;    load = 4'b0001; add_op = 1'b1; end
      OP_MOV_AB:   begin sel = SEL_B;    load = 4'b0001; end
      OP_IN_A:     begin sel = SEL_IN;   load = 4'b0001; end
      OP_MOV_A_IM: begin sel = SEL_ZERO; load = 4'b0001; end
      OP_MOV_BA:   begin sel = SEL_A;    load = 4'b0010; end
      OP_ADD_B:    begin sel = SEL_B;    load = 4'b0010; add_op = 1'b1; end
      OP_IN_B:     begin sel = SEL_IN;   load = 4'b0010; end
      OP_MOV_B_IM: begin sel = SEL_ZERO; load = 4'b0010; end
      OP_OUT_B:    begin sel = SEL_B;    load = 4'b0100; end
      OP_OUT_IM:   begin sel = SEL_ZERO; load = 4'b0100; end
      OP_JMP:      begin sel = SEL_ZERO; load = 4'b1000; end
      // Jump only when the previous instruction left no carry.
      OP_JNC:      begin sel = SEL_ZERO; load = {~carry, 3'b000}; end
      default:     begin sel = SEL_ZERO; load = 4'b0000; end
    endcase
  end

endmodule

// File: rtl/td4_sequencer.sv
// td4_sequencer: fetch/decode/sequencing stage of the 4-bit CPU.
// Holds the PC, a 16x8 program store, the carry flag and the HALT/RUN/STEP
// control FSM, and decodes prog[pc] into datapath control lines.
//   clk, n_reset          clock, synchronous active-low reset
//   run, stop, step       control requests (levels)
//   prog_we/addr/data     program store write port (HALT only)
//   c_in                  datapath adder carry-out, same cycle
//   select_a, select_b    source select
//   load0..load3          write enables A, B, out reg, PC
//   im                    immediate of current instruction
//   pc                    program counter
//   running               high in RUN or STEP
module td4_sequencer
  import td4_pkg::*;
(
  input  logic       clk,
  input  logic       n_reset,
  input  logic       run,
  input  logic       stop,
  input  logic       step,
  input  logic       prog_we,
  input  logic [3:0] prog_addr,
  input  logic [7:0] prog_data,
  input  logic       c_in,
  output logic       select_a,
  output logic       select_b,
  output logic       load0,
  output logic       load1,
  output logic       load2,
  output logic       load3,
  output logic [3:0] im,
  output logic [3:0] pc,
  output logic       running
);

  state_e     state_q, state_d;
  logic       running_q, running_d;
  logic [3:0] pc_q, pc_d;
  logic       carry_q, carry_d;
  logic [7:0] prog_q [16];
  logic [7:0] prog_d [16];

  logic [7:0] instr;
  logic [1:0] dec_sel;
  logic [3:0] dec_load;
  logic       dec_add;
  logic       exec;
  logic [3:0] load;

  // Asynchronous fetch from the flop array: zero fetch latency.
  assign instr = prog_q[pc_q];
  assign exec  = (state_q != HALT);

  td4_decoder u_dec (
    .op     (instr[7:4]),
    .carry  (carry_q),
    .sel    (dec_sel),
    .load   (dec_load),
    .add_op (dec_add)
  );

  assign load     = exec ? dec_load : 4'b0000;
  assign select_a = dec_sel[0];
  assign select_b = dec_sel[1];
  assign load0    = load[0];
  assign load1    = load[1];
  assign load2    = load[2];
  assign load3    = load[3];
  assign im       = instr[3:0];
  assign pc       = pc_q;
  assign running  = running_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      HALT: begin
        if (run)       state_d = RUN;
        else if (step) state_d = STEP;
      end
      RUN:     if (stop) state_d = HALT;
      STEP:    state_d = HALT;
      default: state_d = HALT;
    endcase
    // running tracks the state the FSM is entering, so it is high exactly
    // in the cycles that execute.
    running_d = (state_d != HALT);
  end

  always_comb begin
    pc_d    = pc_q;
    carry_d = carry_q;
    if (exec) begin
      pc_d    = load[3] ? instr[3:0] : pc_q + 4'd1;
      carry_d = dec_add ? c_in : 1'b0;
    end
  end

  always_comb begin
    prog_d = prog_q;
    // Writes are only accepted while halted, so a fetch never races a write.
    if (prog_we && (state_q == HALT)) prog_d[prog_addr] = prog_data;
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q   <= HALT;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      pc_q    <= 4'd0;
      carry_q <= 1'b0;
      prog_q  <= '{default: 8'h00};
    end else begin
      pc_q    <= pc_d;
      carry_q <= carry_d;
      prog_q  <= prog_d;
    end
  end

endmodule

// File: tb/tb_td4_sequencer.sv
module tb_td4_sequencer;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       run = 1'b0, stop = 1'b0, step = 1'b0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = 4'd0;
  logic [7:0] prog_data = 8'h00;
  logic       c_in = 1'b0;
  logic       select_a, select_b, load0, load1, load2, load3, running;
  logic [3:0] im, pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  td4_sequencer dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .run       (run),
    .stop      (stop),
    .step      (step),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .c_in      (c_in),
    .select_a  (select_a),
    .select_b  (select_b),
    .load0     (load0),
    .load1     (load1),
    .load2     (load2),
    .load3     (load3),
    .im        (im),
    .pc        (pc),
    .running   (running)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    run = 0; stop = 0; step = 0; prog_we = 0; c_in = 0;
    n_reset = 0;
    tick();
    tick();
    n_reset = 1;
  endtask

  task automatic write_word(input logic [3:0] a, input logic [7:0] d);
    prog_we = 1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pc !== 4'd0) begin errors++; $display("FAIL reset_pc got %0h want 0", pc); end
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %0b want 0", running); end
    checks++;
    if ({load3, load2, load1, load0} !== 4'b0000) begin
      errors++; $display("FAIL reset_loads got %b want 0000", {load3, load2, load1, load0});
    end
    checks++;
    if (im !== 4'h0) begin errors++; $display("FAIL reset_prog0 got %0h want 0", im); end

    write_word(4'd0, 8'h3A);
    checks++;
    if (load0 !== 1'b0 || im !== 4'hA) begin
      errors++; $display("FAIL halt_gated got load0=%0b im=%0h want load0=0 im=a", load0, im);
    end
    step = 1;
    tick();
    step = 0;
    checks++;
    if (running !== 1'b1 || load0 !== 1'b1 || {select_b, select_a} !== 2'b11 || im !== 4'hA) begin
      errors++;
      $display("FAIL step_decode got run=%0b load0=%0b sel=%b im=%0h want 1 1 11 a",
               running, load0, {select_b, select_a}, im);
    end
    tick();
    checks++;
    if (pc !== 4'd1 || running !== 1'b0 || load0 !== 1'b0) begin
      errors++;
      $display("FAIL step_after got pc=%0h run=%0b load0=%0b want 1 0 0", pc, running, load0);
    end
  endtask

  task automatic load_jnc_prog();
    write_word(4'd0, 8'h30);
    write_word(4'd1, 8'h01);
    write_word(4'd2, 8'hE0);
    write_word(4'd3, 8'hF1);
  endtask

  task automatic test_carry_set();
    logic [3:0] seq [8];
    seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3, 4'd1};
    do_reset();
    load_jnc_prog();
    c_in = 1;
    run = 1;
    tick();
    run = 0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (pc !== seq[i]) begin errors++; $display("FAIL carry1_pc[%0d] got %0h want %0h", i, pc, seq[i]); end
      if (seq[i] == 4'd2) begin
        checks++;
        if (load3 !== 1'b0) begin errors++; $display("FAIL jnc_not_taken got %0b want 0", load3); end
      end
      tick();
    end
    // pc is at the JNC; the stop cycle still executes it.
    stop = 1;
    tick();
    stop = 0;
    checks++;
    if (running !== 1'b0 || pc !== 4'd3) begin
      errors++; $display("FAIL stop_halt got run=%0b pc=%0h want 0 3", running, pc);
    end
    tick();
    checks++;
    if (pc !== 4'd3) begin errors++; $display("FAIL halt_hold_pc got %0h want 3", pc); end
  endtask

  task automatic test_carry_clear();
    logic [3:0] seq [7];
    seq = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0};
    do_reset();
    load_jnc_prog();
    c_in = 0;
    run = 1;
    tick();
    run = 0;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (pc !== seq[i]) begin errors++; $display("FAIL carry0_pc[%0d] got %0h want %0h", i, pc, seq[i]); end
      if (seq[i] == 4'd2) begin
        checks++;
        if (load3 !== 1'b1) begin errors++; $display("FAIL jnc_taken got %0b want 1", load3); end
      end
      tick();
    end
    stop = 1;
    tick();
    stop = 0;
  endtask

  task automatic test_nop_wrap();
    do_reset();
    for (int a = 0; a < 16; a++) write_word(a[3:0], 8'h80);
    run = 1;
    tick();
    run = 0;
    for (int i = 0; i < 18; i++) begin
      logic [3:0] want;
      want = i[3:0];
      checks++;
      if (pc !== want || {load3, load2, load1, load0} !== 4'b0000 || {select_b, select_a} !== 2'b11) begin
        errors++;
        $display("FAIL nop_wrap[%0d] got pc=%0h loads=%b sel=%b want pc=%0h loads=0000 sel=11",
                 i, pc, {load3, load2, load1, load0}, {select_b, select_a}, want);
      end
      tick();
    end
    stop = 1;
    tick();
    stop = 0;
  endtask

  task automatic test_write_in_run();
    do_reset();
    run = 1;
    tick();
    run = 0;
    prog_we = 1; prog_addr = 4'd5; prog_data = 8'h91;
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (pc !== 4'd4) begin errors++; $display("FAIL wr_run_pc got %0h want 4", pc); end
    stop = 1;
    tick();
    stop = 0;
    prog_we = 0;
    checks++;
    if (running !== 1'b0 || pc !== 4'd5) begin
      errors++; $display("FAIL wr_run_halt got run=%0b pc=%0h want 0 5", running, pc);
    end
    checks++;
    if (im !== 4'h0 || {select_b, select_a} !== 2'b00) begin
      errors++; $display("FAIL wr_run_dropped got im=%0h sel=%b want 0 00", im, {select_b, select_a});
    end
    step = 1;
    tick();
    step = 0;
    checks++;
    if (load0 !== 1'b1 || load2 !== 1'b0 || {select_b, select_a} !== 2'b00) begin
      errors++;
      $display("FAIL wr_run_step got load0=%0b load2=%0b sel=%b want 1 0 00", load0, load2, {select_b, select_a});
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    for (int a = 0; a < 16; a++) write_word(a[3:0], 8'h05);
    c_in = 1;
    run = 1;
    tick();
    run = 0;
    for (int k = 0; k < 7; k++) tick();
    checks++;
    if (pc !== 4'd7 || running !== 1'b1) begin
      errors++; $display("FAIL mid_run_pc got pc=%0h run=%0b want 7 1", pc, running);
    end
    n_reset = 0;
    tick();
    n_reset = 1;
    c_in = 0;
    checks++;
    if (pc !== 4'd0 || running !== 1'b0 || im !== 4'h0 || {select_b, select_a} !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset got pc=%0h run=%0b im=%0h sel=%b want 0 0 0 00",
               pc, running, im, {select_b, select_a});
    end
    tick();
    checks++;
    if (pc !== 4'd0 || running !== 1'b0) begin
      errors++; $display("FAIL mid_reset_hold got pc=%0h run=%0b want 0 0", pc, running);
    end
    write_word(4'd0, 8'hE3);
    step = 1;
    tick();
    step = 0;
    checks++;
    if (load3 !== 1'b1) begin errors++; $display("FAIL reset_carry_cleared got load3=%0b want 1", load3); end
    tick();
    checks++;
    if (pc !== 4'd3 || im !== 4'h0) begin
      errors++; $display("FAIL reset_prog_cleared got pc=%0h im=%0h want 3 0", pc, im);
    end
  endtask

  task automatic test_priority();
    do_reset();
    run = 1; step = 1;
    tick();
    run = 0; step = 0;
    checks++;
    if (running !== 1'b1 || pc !== 4'd0) begin
      errors++; $display("FAIL prio_enter got run=%0b pc=%0h want 1 0", running, pc);
    end
    tick();
    checks++;
    if (running !== 1'b1 || pc !== 4'd1) begin
      errors++; $display("FAIL prio_run_not_step got run=%0b pc=%0h want 1 1", running, pc);
    end
    run = 1; stop = 1;
    tick();
    run = 0; stop = 0;
    checks++;
    if (running !== 1'b0 || pc !== 4'd2) begin
      errors++; $display("FAIL prio_stop got run=%0b pc=%0h want 0 2", running, pc);
    end
    tick();
    checks++;
    if (pc !== 4'd2 || running !== 1'b0) begin
      errors++; $display("FAIL prio_hold got run=%0b pc=%0h want 0 2", running, pc);
    end
  endtask

  initial begin
    test_reset();
    test_carry_set();
    test_carry_clear();
    test_nop_wrap();
    test_write_in_run();
    test_reset_mid_run();
    test_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/td4_sequencer.md
# td4_sequencer

Instruction fetch, decode and sequencing stage for the 4-bit CPU datapath. It holds the program counter, a 16×8 program store, the carry flag and a run/step control FSM. Each cycle it decodes `prog[pc]` into the datapath control lines: `select_a`, `select_b`, `load0`..`load3`, `im`. It sits directly upstream of the register/selector/ALU datapath and consumes that datapath's adder carry-out.

## Interface
Parameters:
- none. Widths are fixed: 4-bit data/address, 8-bit instruction.

Ports:
- `clk`  in  1  clock
- `n_reset`  in  1  reset, synchronous, active-low
- `run`  in  1  level; HALT→RUN request
- `stop`  in  1  level; RUN→HALT request
- `step`  in  1  HALT only; execute exactly one instruction
- `prog_we`  in  1  program store write enable; honoured only in HALT
- `prog_addr`  in  4  program store write address
- `prog_data`  in  8  instruction word: [7:4] opcode, [3:0] immediate
- `c_in`  in  1  carry-out of the datapath 4-bit adder, same cycle
- `select_a`, `select_b`  out  1 each  source select {b,a}: 00=A, 01=B, 10=input port, 11=zero
- `load0`, `load1`, `load2`, `load3`  out  1 each  write enable: A, B, output reg, PC/jump
- `im`  out  4  immediate field of current instruction
- `pc`  out  4  program counter
- `running`  out  1  high in RUN or STEP

## Operation
- FSM states:
  - HALT (reset state).
  - HALT→RUN when `run`=1.
  - HALT→STEP when `step`=1 and `run`=0; `run` wins if both are high.
  - STEP→HALT unconditionally after one cycle.
  - RUN→HALT when `stop`=1; `stop` wins over `run`.
- Execute cycle = any cycle in RUN or STEP. In HALT, `load0`..`load3` are forced to 0, and `pc` and the carry flag hold.
- Decode of opcode `op`={select_b,select_a,load}:
  - 0000 ADD A,Im: sel A, load0
  - 0001 MOV A,B: sel B, load0
  - 0010 IN A: sel in, load0
  - 0011 MOV A,Im: sel zero, load0
  - 0100 MOV B,A: sel A, load1
  - 0101 ADD B,Im: sel B, load1
  - 0110 IN B: sel in, load1
  - 0111 MOV B,Im: sel zero, load1
  - 1001 OUT B: sel B, load2
  - 1011 OUT Im: sel zero, load2
  - 1111 JMP Im: sel zero, load3
  - 1110 JNC Im: sel zero, load3 only if carry=0
  - 1000, 1010, 1100, 1101: NOP, sel zero, no load
- PC update on an execute cycle: `pc`←`im` if `load3`=1, else `pc`+1 (mod 16; 15 wraps to 0).
- Carry flag on an execute cycle: ←`c_in` for opcodes 0000/0101; ←0 for every other opcode, including NOP and jumps. JNC tests the flag registered by the previous instruction.
- Program store writes: when `prog_we`=1 in HALT, `prog[prog_addr]`←`prog_data` at the edge. Writes while `running`=1 are dropped silently.
- Reset (`n_reset`=0 at edge): state HALT, `pc`=0, carry=0, all 16 words ←8'h00, `running`=0. Reset overrides any write or execute in the same cycle, including mid-RUN.

## Timing
- Decode outputs (`select_*`, `load*`, `im`) are combinational from `prog[pc]`, the state and the carry flag. They are valid in the same cycle the PC points at the instruction.
- One instruction per cycle; 0 fetch latency. The datapath register, `pc` and the carry update on the same edge.
- `running` is registered. RUN begins executing `prog[pc]` in the cycle after `run` is sampled.
- A write and a later execute of the same address work back-to-back: a write in HALT cycle N, RUN entered at N+1, executes the new word at N+2.
- `prog` reads are asynchronous (flop array). No read-during-write hazard exists, because writes only occur in HALT.

## Structure
- Shared package `td4_pkg`:
  - opcode localparams (OP_ADD_A … OP_JMP)
  - select encodings SEL_A/SEL_B/SEL_IN/SEL_ZERO
  - FSM state enum {HALT, RUN, STEP}
- Sub-module `td4_decoder`: purely combinational; opcode and carry in, select/load out.
- `td4_sequencer` owns the PC, carry, program array and FSM.

## Test plan
- Reset then inspect: `pc`=0, `running`=0, loads all 0; write 8'h3A at addr 0, pulse `step` → one cycle with `load0`=1, sel=11, `im`=A; `pc`=1; then HALT.
- Program {0:30, 1:01, 2:E0, 3:F1} with `c_in`=1 on the ADD, `run` → pc sequence 0,1,2,3,1,2,3…; the JNC at 2 is never taken. With `c_in`=0 → pc goes 0,1,2,0.
- All-NOP program (8'h80), run 17 cycles → `pc` wraps 15→0→1, no load ever asserted.
- `prog_we`=1 to addr 5 with 8'h91 during RUN → `prog[5]` unchanged (verify via later `step`, expect opcode 00 decode).
- `n_reset`=0 mid-RUN at pc=7 → next cycle `pc`=0, HALT, carry=0, `prog` all zero.
- `run`=`step`=1 in HALT → RUN entered, not STEP; `stop`=`run`=1 in RUN → HALT.
